// File: rtl/vx_issue_perf_monitor.sv
// Issue-stage performance monitor: passive taps on the issue-stage handshakes feeding
// saturating event counters, a sticky overflow flag and a longest scoreboard-stall run tracker.
module vx_issue_perf_monitor #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_EX      = 5,
  parameter int EX_BITS     = 3,
  parameter int CTR_W       = 44
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      decode_valid,
  input  logic                      decode_ready,
  input  logic                      issue_valid,
  input  logic                      issue_ready,
  input  logic [NUM_THREADS-1:0]    issue_tmask,
  input  logic                      sboard_valid,
  input  logic                      sboard_ready,
  input  logic                      disp_valid,
  input  logic                      disp_ready,
  input  logic [EX_BITS-1:0]        disp_ex_type,
  input  logic                      clear,
  input  logic                      freeze,
  output logic [CTR_W-1:0]          ibf_stalls,
  output logic [CTR_W-1:0]          scb_stalls,
  output logic [CTR_W-1:0]          scb_max_run,
  output logic [CTR_W-1:0]          issued_instrs,
  output logic [CTR_W-1:0]          active_threads,
  output logic [NUM_EX*CTR_W-1:0]   ex_stalls,
  output logic                      ovf
);

  localparam int PC_W = $clog2(NUM_THREADS + 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  // Returns {saturated, sum}; the sum clamps at all-ones.
  function automatic logic [CTR_W:0] sat_add(input logic [CTR_W-1:0] a,
                                             input logic [CTR_W-1:0] b);
    logic [CTR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CTR_W]) s = {1'b1, CTR_MAX};
    return s;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_THREADS-1:0] m);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_THREADS; i++) c = c + PC_W'(m[i]);
    return c;
  endfunction

  // Stage p0: handshake decode
  logic               ibf_stall_p0, scb_stall_p0, issue_fire_p0, disp_stall_p0;
  logic [EX_BITS-1:0] ex_idx_p0;

  assign ibf_stall_p0  = decode_valid & ~decode_ready;
  assign scb_stall_p0  = sboard_valid & ~sboard_ready;
  assign issue_fire_p0 = issue_valid & issue_ready;
  assign disp_stall_p0 = disp_valid & ~disp_ready;
  assign ex_idx_p0     = (disp_ex_type > EX_BITS'(NUM_EX - 1)) ? EX_BITS'(NUM_EX - 1)
                                                                : disp_ex_type;

  logic [CTR_W-1:0] ibf_p1, scb_p1, max_p1, iss_p1, act_p1, run_p1;
  logic [CTR_W-1:0] ex_p1 [NUM_EX];
  logic             ovf_p1;

  logic [CTR_W-1:0] ibf_nxt, scb_nxt, max_nxt, iss_nxt, act_nxt, run_nxt;
  logic [CTR_W-1:0] ex_nxt [NUM_EX];
  logic             ibf_o, scb_o, iss_o, act_o, run_o;
  logic [NUM_EX-1:0] ex_o;
  logic             ovf_nxt;

  always_comb begin
    {ibf_o, ibf_nxt} = sat_add(ibf_p1, CTR_W'(ibf_stall_p0));
    {scb_o, scb_nxt} = sat_add(scb_p1, CTR_W'(scb_stall_p0));
    {iss_o, iss_nxt} = sat_add(iss_p1, CTR_W'(issue_fire_p0));
    {act_o, act_nxt} = sat_add(act_p1, issue_fire_p0 ? CTR_W'(popcount(issue_tmask))
                                                     : '0);
    // The run length including this stall cycle is what scb_max_run compares against.
    if (scb_stall_p0) begin
      {run_o, run_nxt} = sat_add(run_p1, CTR_W'(1));
    end else begin
      run_o   = 1'b0;
      run_nxt = '0;
    end
    max_nxt = (scb_stall_p0 && (run_nxt > max_p1)) ? run_nxt : max_p1;
    for (int i = 0; i < NUM_EX; i++) begin
      {ex_o[i], ex_nxt[i]} = sat_add(ex_p1[i],
                                     CTR_W'(disp_stall_p0 && (ex_idx_p0 == EX_BITS'(i))));
    end
    ovf_nxt = ovf_p1 | ibf_o | scb_o | iss_o | act_o | run_o | (|ex_o);
  end

  // Stage p1: counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ibf_p1 <= '0;
      scb_p1 <= '0;
      max_p1 <= '0;
      iss_p1 <= '0;
      act_p1 <= '0;
      run_p1 <= '0;
      ovf_p1 <= 1'b0;
      for (int i = 0; i < NUM_EX; i++) ex_p1[i] <= '0;
    end else if (clear) begin
      ibf_p1 <= '0;
      scb_p1 <= '0;
      max_p1 <= '0;
      iss_p1 <= '0;
      act_p1 <= '0;
      run_p1 <= '0;
      ovf_p1 <= 1'b0;
      for (int i = 0; i < NUM_EX; i++) ex_p1[i] <= '0;
    end else if (!freeze) begin
      ibf_p1 <= ibf_nxt;
      scb_p1 <= scb_nxt;
      max_p1 <= max_nxt;
      iss_p1 <= iss_nxt;
      act_p1 <= act_nxt;
      run_p1 <= run_nxt;
      ovf_p1 <= ovf_nxt;
      for (int i = 0; i < NUM_EX; i++) ex_p1[i] <= ex_nxt[i];
    end
  end

  assign ibf_stalls     = ibf_p1;
  assign scb_stalls     = scb_p1;
  assign scb_max_run    = max_p1;
  assign issued_instrs  = iss_p1;
  assign active_threads = act_p1;
  assign ovf            = ovf_p1;

  for (genvar g = 0; g < NUM_EX; g++) begin : g_ex_out
    assign ex_stalls[g*CTR_W +: CTR_W] = ex_p1[g];
  end

endmodule

// File: tb/tb_vx_issue_perf_monitor.sv
// Directed bench for vx_issue_perf_monitor: a default-width instance plus an 8-bit
// counter instance driven by the same stimulus for the saturation case.
module tb_vx_issue_perf_monitor;

  localparam int NT = 4;
  localparam int NE = 5;
  localparam int EB = 3;
  localparam int CW = 44;
  localparam int CW8 = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          decode_valid, decode_ready;
  logic          issue_valid, issue_ready;
  logic [NT-1:0] issue_tmask;
  logic          sboard_valid, sboard_ready;
  logic          disp_valid, disp_ready;
  logic [EB-1:0] disp_ex_type;
  logic          clear, freeze;

  logic [CW-1:0]    ibf_stalls, scb_stalls, scb_max_run, issued_instrs, active_threads;
  logic [NE*CW-1:0] ex_stalls;
  logic             ovf;

  logic [CW8-1:0]    ibf8, scb8, max8, iss8, act8;
  logic [NE*CW8-1:0] ex8;
  logic              ovf8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vx_issue_perf_monitor #(.NUM_THREADS(NT), .NUM_EX(NE), .EX_BITS(EB), .CTR_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .decode_valid(decode_valid), .decode_ready(decode_ready),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tmask(issue_tmask),
    .sboard_valid(sboard_valid), .sboard_ready(sboard_ready),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ex_type(disp_ex_type),
    .clear(clear), .freeze(freeze),
    .ibf_stalls(ibf_stalls), .scb_stalls(scb_stalls), .scb_max_run(scb_max_run),
    .issued_instrs(issued_instrs), .active_threads(active_threads),
    .ex_stalls(ex_stalls), .ovf(ovf)
  );

  vx_issue_perf_monitor #(.NUM_THREADS(NT), .NUM_EX(NE), .EX_BITS(EB), .CTR_W(CW8)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .decode_valid(decode_valid), .decode_ready(decode_ready),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tmask(issue_tmask),
    .sboard_valid(sboard_valid), .sboard_ready(sboard_ready),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ex_type(disp_ex_type),
    .clear(clear), .freeze(freeze),
    .ibf_stalls(ibf8), .scb_stalls(scb8), .scb_max_run(max8),
    .issued_instrs(iss8), .active_threads(act8),
    .ex_stalls(ex8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    decode_valid = 1'b0; decode_ready = 1'b0;
    issue_valid  = 1'b0; issue_ready  = 1'b0; issue_tmask = 'x;
    sboard_valid = 1'b0; sboard_ready = 1'b0;
    disp_valid   = 1'b0; disp_ready   = 1'b0; disp_ex_type = 'x;
    clear = 1'b0; freeze = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ibf"}, 64'(ibf_stalls), 64'd0);
    chk({tag, "_scb"}, 64'(scb_stalls), 64'd0);
    chk({tag, "_max"}, 64'(scb_max_run), 64'd0);
    chk({tag, "_iss"}, 64'(issued_instrs), 64'd0);
    chk({tag, "_act"}, 64'(active_threads), 64'd0);
    chk({tag, "_ex"}, 64'(|ex_stalls), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    #12;
    chk_all_zero("rst");
    step(1);
    reset_n = 1'b1;
    step(1);
    chk_all_zero("post_rst");

    // 1: async reset in the middle of counting
    decode_valid = 1'b1; decode_ready = 1'b0;
    step(7);
    chk("t1_ibf7", 64'(ibf_stalls), 64'd7);
    reset_n = 1'b0;
    #1;
    chk("t1_async_ibf", 64'(ibf_stalls), 64'd0);
    chk("t1_async_ovf", 64'(ovf), 64'd0);
    decode_valid = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("t1_hold_ibf", 64'(ibf_stalls), 64'd0);

    // 2: issue fires and thread popcount accumulation
    issue_valid = 1'b1; issue_ready = 1'b1;
    issue_tmask = 4'b1111; step(1);
    chk("t2_act_first", 64'(active_threads), 64'd4);
    issue_tmask = 4'b0101; step(1);
    issue_tmask = 4'b0000; step(1);
    chk("t2_iss", 64'(issued_instrs), 64'd3);
    chk("t2_act", 64'(active_threads), 64'd6);
    issue_ready = 1'b0; issue_tmask = 4'b1111; step(1);
    chk("t2_nofire_iss", 64'(issued_instrs), 64'd3);
    chk("t2_nofire_act", 64'(active_threads), 64'd6);
    idle();

    // 3: per-unit dispatch stalls, out-of-range type folds into the last channel
    do_reset();
    disp_valid = 1'b1; disp_ready = 1'b0;
    disp_ex_type = 3'd1; step(2);
    disp_ex_type = 3'd7; step(1);
    disp_ready = 1'b1; disp_ex_type = 3'd0; step(1);
    idle(); step(1);
    chk("t3_ex0", 64'(ex_stalls[0*CW +: CW]), 64'd0);
    chk("t3_ex1", 64'(ex_stalls[1*CW +: CW]), 64'd2);
    chk("t3_ex2", 64'(ex_stalls[2*CW +: CW]), 64'd0);
    chk("t3_ex3", 64'(ex_stalls[3*CW +: CW]), 64'd0);
    chk("t3_ex4", 64'(ex_stalls[4*CW +: CW]), 64'd1);

    // 4: scoreboard stall runs of 3 and 5 separated by one grant
    do_reset();
    sboard_valid = 1'b1; sboard_ready = 1'b0;
    step(1);
    chk("t4_max_1", 64'(scb_max_run), 64'd1);
    step(2);
    chk("t4_max_run1", 64'(scb_max_run), 64'd3);
    sboard_ready = 1'b1; step(1);
    chk("t4_max_gap", 64'(scb_max_run), 64'd3);
    sboard_ready = 1'b0; step(3);
    chk("t4_max_mid", 64'(scb_max_run), 64'd3);
    step(1);
    chk("t4_max_4", 64'(scb_max_run), 64'd4);
    step(1);
    idle(); step(1);
    chk("t4_scb", 64'(scb_stalls), 64'd8);
    chk("t4_max", 64'(scb_max_run), 64'd5);

    // 5: saturation on the 8-bit instance, then clear
    do_reset();
    decode_valid = 1'b1; decode_ready = 1'b0;
    step(254);
    chk("t5_ibf8_254", 64'(ibf8), 64'd254);
    chk("t5_ovf8_pre", 64'(ovf8), 64'd0);
    step(1);
    chk("t5_ibf8_255", 64'(ibf8), 64'd255);
    chk("t5_ovf8_at_max", 64'(ovf8), 64'd0);
    step(5);
    chk("t5_ibf8_sat", 64'(ibf8), 64'd255);
    chk("t5_ovf8", 64'(ovf8), 64'd1);
    chk("t5_ibf_wide", 64'(ibf_stalls), 64'd260);
    chk("t5_ovf_wide", 64'(ovf), 64'd0);
    decode_valid = 1'b0;
    clear = 1'b1; step(1);
    clear = 1'b0; step(1);
    chk("t5_clr_ibf8", 64'(ibf8), 64'd0);
    chk("t5_clr_ovf8", 64'(ovf8), 64'd0);

    // 6: freeze holds everything including the open run; clear drops same-cycle events
    do_reset();
    decode_valid = 1'b1; decode_ready = 1'b0;
    sboard_valid = 1'b1; sboard_ready = 1'b0;
    issue_valid = 1'b1; issue_ready = 1'b1; issue_tmask = 4'b0011;
    step(1);
    issue_valid = 1'b0; issue_tmask = 'x;
    step(1);
    issue_valid = 1'b1; issue_tmask = 4'b1111;
    disp_valid = 1'b1; disp_ready = 1'b0; disp_ex_type = 3'd0;
    freeze = 1'b1;
    step(4);
    chk("t6_frz_ibf", 64'(ibf_stalls), 64'd2);
    chk("t6_frz_iss", 64'(issued_instrs), 64'd1);
    chk("t6_frz_act", 64'(active_threads), 64'd2);
    chk("t6_frz_scb", 64'(scb_stalls), 64'd2);
    chk("t6_frz_max", 64'(scb_max_run), 64'd2);
    chk("t6_frz_ex", 64'(|ex_stalls), 64'd0);
    idle();
    sboard_valid = 1'b1; sboard_ready = 1'b0;
    step(1);
    chk("t6_resume_scb", 64'(scb_stalls), 64'd3);
    chk("t6_resume_max", 64'(scb_max_run), 64'd3);
    decode_valid = 1'b1;
    issue_valid = 1'b1; issue_ready = 1'b1; issue_tmask = 4'b1111;
    disp_valid = 1'b1; disp_ex_type = 3'd2;
    clear = 1'b1;
    step(1);
    idle();
    chk_all_zero("t6_clr");
    step(1);
    chk_all_zero("t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
